// File: rtl/rv_i_type_controller_pkg.sv
// Shared encodings for the I/R-type controller: FSM states, ALU control codes
// (also consumed by the ALU), opcode and funct7 constants.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_TRAP
  } state_e;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD  = 4'd0;
  localparam alu_ctrl_t ALU_SUB  = 4'd1;
  localparam alu_ctrl_t ALU_SLL  = 4'd2;
  localparam alu_ctrl_t ALU_SLT  = 4'd3;
  localparam alu_ctrl_t ALU_SLTU = 4'd4;
  localparam alu_ctrl_t ALU_XOR  = 4'd5;
  localparam alu_ctrl_t ALU_SRL  = 4'd6;
  localparam alu_ctrl_t ALU_SRA  = 4'd7;
  localparam alu_ctrl_t ALU_OR   = 4'd8;
  localparam alu_ctrl_t ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operation selected by funct3 alone; SUB/SRA overrides are applied by the decoder.
  function automatic alu_ctrl_t base_alu_op(input logic [2:0] funct3);
    alu_ctrl_t op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_i_type_controller_if.sv
// Instruction-memory fetch handshake between the controller and instruction memory.
interface rv_i_type_controller_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;

  modport master (
    output imem_req,
    input  imem_ack,
    input  instr
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output instr
  );
endinterface

// File: rtl/rv_i_type_controller_decoder.sv
// Combinational decode of an I/R-type instruction word into ALU control,
// operand-B select, rd-nonzero and legality.
module rv_i_type_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   alu_ctrl,
  output logic        alu_src_imm,
  output logic        rd_nz,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign rd_nz         = (instr[11:7] != 5'd0);
  assign unused_fields = ^instr[24:15];

  always_comb begin
    alu_ctrl    = base_alu_op(funct3);
    alu_src_imm = 1'b0;
    legal       = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        alu_src_imm = 1'b1;
        // funct7 only constrains the shift-immediates; other funct3 carry plain imm bits.
        case (funct3)
          3'b001: legal = (funct7 == F7_BASE);
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000: begin
              legal    = 1'b1;
              alu_ctrl = ALU_SUB;
            end
            3'b101: begin
              legal    = 1'b1;
              alu_ctrl = ALU_SRA;
            end
            default: legal = 1'b0;
          endcase
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_i_type_controller.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/writeback for the
// I/R-type datapath, with imem-timeout and illegal-instruction traps.
module rv_i_type_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  rv_i_type_controller_if.master        imem,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic                          rf_we,
  output logic                          alu_src_imm,
  output logic [3:0]                    alu_ctrl,
  output logic                          busy,
  output logic                          illegal,
  output logic                          bus_err,
  output logic [31:0]                   retired
);

  localparam int unsigned TW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IMEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  alu_ctrl_t   alu_ctrl_q, alu_ctrl_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic        rd_nz_q, rd_nz_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req;

  alu_ctrl_t   dec_alu_ctrl;
  logic        dec_alu_src_imm;
  logic        dec_rd_nz;
  logic        dec_legal;

  rv_i_type_decoder u_dec (
    .instr       (imem.instr),
    .alu_ctrl    (dec_alu_ctrl),
    .alu_src_imm (dec_alu_src_imm),
    .rd_nz       (dec_rd_nz),
    .legal       (dec_legal)
  );

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_src_imm_d = alu_src_imm_q;
    rd_nz_d       = rd_nz_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    retired_d     = retired_q;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    busy          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem.imem_ack) begin
          ir_we   = 1'b1;
          tmo_d   = '0;
          state_d = ST_DECODE;
        end else begin
          // This miss is the IMEM_TIMEOUT-th in a row: trap instead of retrying.
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            bus_err_d = 1'b1;
            state_d   = ST_TRAP;
          end
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          alu_ctrl_d    = dec_alu_ctrl;
          alu_src_imm_d = dec_alu_src_imm;
          rd_nz_d       = dec_rd_nz;
          state_d       = ST_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_we     = 1'b1;
        rf_we     = rd_nz_q;
        retired_d = retired_q + 32'd1;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        busy = 1'b0;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      alu_ctrl_q    <= ALU_ADD;
      alu_src_imm_q <= 1'b0;
      rd_nz_q       <= 1'b0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_src_imm_q <= alu_src_imm_d;
      rd_nz_q       <= rd_nz_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      retired_q     <= retired_d;
    end
  end

  assign imem.imem_req = imem_req;
  assign alu_ctrl      = alu_ctrl_q;
  assign alu_src_imm   = alu_src_imm_q;
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_rv_i_type_controller.sv
// Self-checking bench: per-cycle expectations built from an instruction-level
// model, compared on the falling edge, plus directed literal checks.
module tb_rv_i_type_controller;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        ir_we, pc_we, rf_we, alu_src_imm, busy, illegal, bus_err;
  logic [3:0]  alu_ctrl;
  logic [31:0] retired;

  rv_i_type_controller_if bus ();

  rv_i_type_controller #(.IMEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem        (bus),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .alu_src_imm (alu_src_imm),
    .alu_ctrl    (alu_ctrl),
    .busy        (busy),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, irwe, pcwe, rfwe, busy, ill, berr, chk_alu, src;
    logic [3:0]  alu;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instruction-level model state
  logic [31:0] m_ret  = 0;
  logic        m_ill  = 0;
  logic        m_berr = 0;
  logic [3:0]  m_alu  = 0;
  logic        m_src  = 0;

  logic [3:0]  f3_code [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic [3:0]  wb_alu;
  logic        wb_src, wb_rf, wb_pc;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      cmp("imem_req", 32'(bus.imem_req), 32'(ce.req));
      cmp("ir_we",    32'(ir_we),        32'(ce.irwe));
      cmp("pc_we",    32'(pc_we),        32'(ce.pcwe));
      cmp("rf_we",    32'(rf_we),        32'(ce.rfwe));
      cmp("busy",     32'(busy),         32'(ce.busy));
      cmp("illegal",  32'(illegal),      32'(ce.ill));
      cmp("bus_err",  32'(bus_err),      32'(ce.berr));
      cmp("retired",  retired,           ce.ret);
      if (ce.chk_alu) begin
        cmp("alu_ctrl",    32'(alu_ctrl),    32'(ce.alu));
        cmp("alu_src_imm", 32'(alu_src_imm), 32'(ce.src));
      end
    end
  end

  function automatic exp_t mk(input logic req, irwe, pcwe, rfwe, bsy, chk);
    exp_t e;
    e.req = req; e.irwe = irwe; e.pcwe = pcwe; e.rfwe = rfwe; e.busy = bsy;
    e.ill = m_ill; e.berr = m_berr; e.chk_alu = chk;
    e.alu = m_alu; e.src = m_src; e.ret = m_ret;
    return e;
  endfunction

  // Reference decode from the ISA legality rules
  function automatic void ref_dec(input logic [31:0] i, output bit legal,
                                  output logic [3:0] code, output bit imm);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    imm = 0;
    code = f3_code[f3];
    legal = 0;
    if (i[6:0] == 7'h13) begin
      imm = 1;
      legal = !(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      if (f3 == 3'd5 && f7 == 7'h20) code = 4'd7;
    end else if (i[6:0] == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (f7 == 7'h20) code = (f3 == 3'd0) ? 4'd1 : 4'd7;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    int unsigned k;
    k = $urandom_range(0, 9);
    opc = (k < 5) ? 7'h13 : (k < 9) ? 7'h33 : 7'($urandom);
    k = $urandom_range(0, 3);
    f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic step(input logic r, input logic a, input logic [31:0] ins,
                      input logic rs, input exp_t e);
    run = r;
    bus.imem_ack = a;
    bus.instr = ins;
    rst = rs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic r);
    step(r, 1'($urandom), $urandom, 1'b0, mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic trap_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      step(1'($urandom), 1'($urandom), $urandom, 1'b0, mk(0, 0, 0, 0, 0, 0));
  endtask

  // Only called from IDLE or TRAP, where every enable and busy are low
  task automatic do_reset();
    step(1'b0, 1'($urandom), $urandom, 1'b1, mk(0, 0, 0, 0, 0, 0));
    m_ret = 0; m_ill = 0; m_berr = 0; m_alu = 0; m_src = 0;
  endtask

  // outcome: 0 = IDLE next, 1 = FETCH next, 2 = trapped
  task automatic do_instr(input logic [31:0] ins, input int unsigned dly,
                          input logic run_end, input bit abort_ex,
                          output int unsigned outcome);
    int unsigned nmiss;
    bit          legal, imm;
    logic [3:0]  code;
    nmiss = (dly < TMO) ? dly : TMO;
    for (int unsigned i = 0; i < nmiss; i++)
      step(1'($urandom), 1'b0, $urandom, 1'b0, mk(1, 0, 0, 0, 1, 0));
    if (dly >= TMO) begin
      m_berr = 1;
      trap_cycles(3);
      outcome = 2;
      return;
    end
    step(1'($urandom), 1'b1, $urandom, 1'b0, mk(1, 1, 0, 0, 1, 0));
    step(1'($urandom), 1'($urandom), ins, 1'b0, mk(0, 0, 0, 0, 1, 0));
    ref_dec(ins, legal, code, imm);
    if (!legal) begin
      m_ill = 1;
      trap_cycles(3);
      outcome = 2;
      return;
    end
    m_alu = code;
    m_src = imm;
    if (abort_ex) begin
      step(1'b0, 1'($urandom), ins, 1'b1, mk(0, 0, 0, 0, 1, 1));
      m_ret = 0; m_ill = 0; m_berr = 0; m_alu = 0; m_src = 0;
      outcome = 0;
      return;
    end
    step(1'($urandom), 1'($urandom), ins, 1'b0, mk(0, 0, 0, 0, 1, 1));
    wb_alu = alu_ctrl;
    wb_src = alu_src_imm;
    wb_rf  = rf_we;
    wb_pc  = pc_we;
    step(run_end, 1'($urandom), ins, 1'b0, mk(0, 0, 1, ins[11:7] != 5'd0, 1, 1));
    m_ret = m_ret + 1;
    outcome = run_end ? 1 : 0;
  endtask

  int unsigned outcome;
  int unsigned dly;
  logic [3:0]  a1;
  logic        s1;

  initial begin
    rst = 1'b1;
    run = 1'b0;
    bus.imem_ack = 1'b0;
    bus.instr = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_imem_req", 32'(bus.imem_req), 32'd0);
    cmp("rst_busy",     32'(busy),         32'd0);
    cmp("rst_retired",  retired,           32'd0);
    cmp("rst_alu_ctrl", 32'(alu_ctrl),     32'd0);
    cmp("rst_alu_src",  32'(alu_src_imm),  32'd0);
    cmp("rst_flags",    32'({illegal, bus_err, ir_we, pc_we, rf_we}), 32'd0);

    repeat (4) idle_cycle(1'b0);

    // Single ADDI x1,x0,5
    idle_cycle(1'b1);
    do_instr(32'h00500093, 0, 1'b0, 0, outcome);
    cmp("addi_alu_ctrl", 32'(wb_alu), 32'd0);
    cmp("addi_alu_src",  32'(wb_src), 32'd1);
    cmp("addi_rf_we",    32'(wb_rf),  32'd1);
    cmp("addi_retired",  retired,     32'd1);

    // SRAI back-to-back with SUB
    idle_cycle(1'b1);
    do_instr(32'h4020D113, 0, 1'b1, 0, outcome);
    a1 = wb_alu;
    s1 = wb_src;
    do_instr(32'h402081B3, 0, 1'b0, 0, outcome);
    cmp("srai_alu_ctrl", 32'(a1),     32'd7);
    cmp("srai_alu_src",  32'(s1),     32'd1);
    cmp("sub_alu_ctrl",  32'(wb_alu), 32'd1);
    cmp("sub_alu_src",   32'(wb_src), 32'd0);
    cmp("pair_retired",  retired,     32'd3);

    // Write to x0
    idle_cycle(1'b1);
    do_instr(32'h00000013, 0, 1'b0, 0, outcome);
    cmp("x0_pc_we",   32'(wb_pc), 32'd1);
    cmp("x0_rf_we",   32'(wb_rf), 32'd0);
    cmp("x0_retired", retired,    32'd4);

    // Illegal all-zero word
    idle_cycle(1'b1);
    do_instr(32'h00000000, 0, 1'b0, 0, outcome);
    cmp("ill_illegal", 32'(illegal), 32'd1);
    cmp("ill_busy",    32'(busy),    32'd0);
    cmp("ill_retired", retired,      32'd4);
    do_reset();

    // Instruction-memory timeout
    idle_cycle(1'b1);
    do_instr(32'h00500093, TMO, 1'b0, 0, outcome);
    cmp("tmo_bus_err",  32'(bus_err),      32'd1);
    cmp("tmo_imem_req", 32'(bus.imem_req), 32'd0);
    do_reset();
    cmp("post_rst_bus_err", 32'(bus_err),  32'd0);
    cmp("post_rst_illegal", 32'(illegal),  32'd0);
    cmp("post_rst_busy",    32'(busy),     32'd0);

    // Longest ack delay that still avoids the trap, then reset during EXECUTE
    idle_cycle(1'b1);
    do_instr(32'h00100113, TMO - 1, 1'b1, 0, outcome);
    cmp("slow_ack_retired", retired, 32'd1);
    do_instr(32'h00500093, 0, 1'b1, 1, outcome);
    cmp("abort_retired", retired, 32'd0);
    cmp("abort_busy",    32'(busy), 32'd0);

    repeat (20) idle_cycle(1'b0);

    // Randomized instruction stream
    outcome = 0;
    for (int n = 0; n < 60; n++) begin
      if (outcome == 0) begin
        repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
      case ($urandom_range(0, 19))
        0:       dly = TMO;
        1, 2:    dly = TMO - 1;
        default: dly = $urandom_range(0, 3);
      endcase
      do_instr(rand_instr(), dly, 1'($urandom), 0, outcome);
      if (outcome == 2) begin
        do_reset();
        outcome = 0;
      end
    end
    if (outcome == 1) do_instr(32'h00000013, 0, 1'b0, 0, outcome);
    idle_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
